// File: rtl/seg_timer_pkg.sv
// Shared segment encoding and BCD helpers for the seg_timer block.
// Segment bytes are active-low {dp,g,f,e,d,c,b,a}; the decimal point is always off.
package seg_timer_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Non-decimal nibbles saturate to 9 so the counter never holds an illegal digit.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/seg_scan.sv
// Multiplexed 7-segment scanner: dwell counter, digit index, leading-zero
// blanking and registered segment/select outputs for a DIGITS-wide BCD value.
module seg_scan #(
  parameter int DIGITS   = 6,
  parameter int SCAN_DIV = 50_000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [7:0]            seg_led,
  output logic [DIGITS-1:0]     seg_sel
);
  import seg_timer_pkg::*;

  localparam int DW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

  logic [DW-1:0]     dwell_q, dwell_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [7:0]        led_q, led_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [3:0]        digit [DIGITS];
  logic [DIGITS-1:0] shown;

  always_comb begin
    for (int i = 0; i < DIGITS; i++) digit[i] = bcd[4*i +: 4];
  end

  // A digit is lit if it or any digit above it is nonzero; digit 0 is always lit.
  always_comb begin : blank_p
    logic nz;
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    nz    = 1'b0;
    shown = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz       = nz | (digit[i] != 4'd0);
      shown[i] = nz | (i == 0);
    end
  end

  always_comb begin
    dwell_d = dwell_q + DW'(1);
    idx_d   = idx_q;
    if (dwell_q == DWELL_MAX) begin
      dwell_d = '0;
      idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end
    // Select and segments are derived from the same index so they change together.
    sel_d = ~(DIGITS'(1) << idx_q);
    led_d = shown[idx_q] ? bcd_to_seg(digit[idx_q]) : SEG_BLANK;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dwell_q <= '0;
      idx_q   <= '0;
      sel_q   <= ~DIGITS'(1);
      led_q   <= SEG_0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      dwell_q <= dwell_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      led_q   <= led_d;
    end
  end

  assign seg_led = led_q;
  assign seg_sel = sel_q;

endmodule

// File: rtl/seg_timer.sv
// N-digit BCD up/down timer with run/pause, parallel load, terminal-count pulse
// and an attached multiplexed common-anode 7-segment display driver.
module seg_timer #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TICK_HZ  = 10,
  parameter int SCAN_HZ  = 1000,
  parameter int DIGITS   = 6
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                mode,
  input  logic                run,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count_val,
  output logic                count_zero,
  output logic                count_done,
  output logic [7:0]          seg_led,
  output logic [DIGITS-1:0]   seg_sel
);
  import seg_timer_pkg::*;

  localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int SCAN_DIV = CLK_FREQ / SCAN_HZ;
  localparam int PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]       presc_q, presc_d;
  logic [4*DIGITS-1:0] count_q, count_d;
  logic                done_q, done_d;
  logic [4*DIGITS-1:0] step_val;
  logic                step_carry;
  logic                tick;

  // Prescaler freezes while paused so resuming keeps the tick phase.
  always_comb begin
    tick    = run && (presc_q == PRESC_MAX);
    presc_d = presc_q;
    if (load)     presc_d = '0;
    else if (run) presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Ripple BCD +/-1; a carry out of the top digit means all-9s wrapped (up)
  // or the count was already zero (down).
  always_comb begin : bcd_step_p
    logic [3:0] d;
    step_carry = 1'b1;
    step_val   = count_q;
    d          = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      d = count_q[4*i +: 4];
      if (step_carry) begin
        if (mode) begin
          step_val[4*i +: 4] = (d == 4'd9) ? 4'd0 : d + 4'd1;
          step_carry         = (d == 4'd9);
        end else begin
          step_val[4*i +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
          step_carry         = (d == 4'd0);
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    done_d  = 1'b0;
    if (load) begin
      for (int i = 0; i < DIGITS; i++) count_d[4*i +: 4] = bcd_clamp(load_val[4*i +: 4]);
    end else if (tick) begin
      if (mode) begin
        count_d = step_val;
        done_d  = step_carry;
      end else if (!step_carry) begin
        count_d = step_val;
        done_d  = (step_val == '0);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      presc_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign count_val  = count_q;
  assign count_zero = (count_q == '0);
  assign count_done = done_q;

  seg_scan #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bcd       (count_q),
    .seg_led   (seg_led),
    .seg_sel   (seg_sel)
  );

endmodule

// File: tb/tb_seg_timer.sv
// Self-checking bench for seg_timer: vector table, hand-written corner sequences
// and randomized traffic against an integer-arithmetic reference model.
module tb_seg_timer;

  localparam int TICK_DIV = 10;
  localparam int SCAN_DIV = 4;
  localparam int ND       = 4;
  localparam int MODULUS  = 10000;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        mode      = 1'b0;
  logic        run       = 1'b0;
  logic        load      = 1'b0;
  logic [15:0] load_val  = 16'h0000;
  logic [15:0] count_val;
  logic        count_zero;
  logic        count_done;
  logic [7:0]  seg_led;
  logic [3:0]  seg_sel;

  seg_timer #(
    .CLK_FREQ (100),
    .TICK_HZ  (10),
    .SCAN_HZ  (25),
    .DIGITS   (4)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .mode       (mode),
    .run        (run),
    .load       (load),
    .load_val   (load_val),
    .count_val  (count_val),
    .count_zero (count_zero),
    .count_done (count_done),
    .seg_led    (seg_led),
    .seg_sel    (seg_sel)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Reference model state: count as a plain integer, phases as integers.
  int         m_count, m_presc, m_dwell, m_idx;
  logic       m_done;
  logic [3:0] m_sel;
  logic [7:0] m_led;

  typedef struct {
    bit          run;
    bit          mode;
    bit          load;
    logic [15:0] lv;
    int          cycles;
    logic [15:0] exp_count;
    int          exp_pulses;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pow10(input int n);
    int r = 1;
    for (int k = 0; k < n; k++) r *= 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int c);
    logic [15:0] v = '0;
    for (int i = 0; i < ND; i++) v[4*i +: 4] = 4'((c / pow10(i)) % 10);
    return v;
  endfunction

  function automatic int from_load(input logic [15:0] lv);
    int c = 0;
    for (int i = 0; i < ND; i++) begin
      int d;
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 9;
      c += d * pow10(i);
    end
    return c;
  endfunction

  function automatic logic [7:0] disp(input int c, input int i);
    if (i != 0 && c < pow10(i)) return 8'hFF;
    return seg_tab[(c / pow10(i)) % 10];
  endfunction

  task automatic model_reset();
    m_count = 0; m_presc = 0; m_dwell = 0; m_idx = 0;
    m_done  = 1'b0; m_sel = 4'b1110; m_led = 8'hC0;
  endtask

  task automatic model_edge(input bit r, input bit m, input bit l, input logic [15:0] lv);
    bit tick;
    tick  = r && (m_presc == TICK_DIV - 1);
    m_sel = ~(4'b0001 << m_idx);
    m_led = disp(m_count, m_idx);
    if (m_dwell == SCAN_DIV - 1) begin
      m_dwell = 0;
      m_idx   = (m_idx + 1) % ND;
    end else m_dwell++;
    m_done = 1'b0;
    if (l) begin
      m_count = from_load(lv);
      m_presc = 0;
    end else begin
      if (tick) begin
        if (m) begin
          m_count = (m_count + 1) % MODULUS;
          m_done  = (m_count == 0);
        end else if (m_count > 0) begin
          m_count--;
          m_done = (m_count == 0);
        end
      end
      if (r) m_presc = (m_presc + 1) % TICK_DIV;
    end
  endtask

  task automatic check_all();
    check("count_val",  count_val,  to_bcd(m_count));
    check("count_zero", count_zero, m_count == 0);
    check("count_done", count_done, m_done);
    check("seg_sel",    seg_sel,    m_sel);
    check("seg_led",    seg_led,    m_led);
  endtask

  // Called at a negedge: drive, clock the model with the DUT, compare at next negedge.
  task automatic step(input bit r, input bit m, input bit l, input logic [15:0] lv);
    run = r; mode = m; load = l; load_val = lv;
    @(posedge sys_clk);
    model_edge(r, m, l, lv);
    @(negedge sys_clk);
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_sel;
    logic [7:0] seen [4];
    int         pulses;
    bit         r, m, l;
    logic [15:0] lv;

    vecs[0]  = '{1'b1, 1'b0, 1'b1, 16'h0012, 121, 16'h0000, 1};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000,  30, 16'h0000, 0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 16'h9998,  11, 16'h9999, 0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 16'h0000,  10, 16'h0000, 1};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 16'h1000,  11, 16'h0999, 0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'h0050,  38, 16'h0050, 0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 16'h0123,  31, 16'h0126, 0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'h0000,  20, 16'h0124, 0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 16'hABCF,   1, 16'h9999, 0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 16'h0001,  11, 16'h0000, 1};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 16'h0009,  11, 16'h0010, 0};

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_sel",   seg_sel,    4'b1110);
    check("rst_led",   seg_led,    8'hC0);
    check("rst_zero",  count_zero, 1'b1);
    check("rst_done",  count_done, 1'b0);
    check("rst_count", count_val,  16'h0000);
    sys_rst_n = 1'b1;
    model_reset();

    // Scan order after reset and first tick TICK_DIV cycles after run rises
    for (int e = 1; e <= 16; e++) begin
      step(1'b1, 1'b1, 1'b0, 16'h0000);
      exp_sel = ~(4'b0001 << ((e - 1) / 4));
      check("scan_sel", seg_sel, exp_sel);
      check("scan_led", seg_led, ((e - 1) / 4 == 0) ? 8'hC0 : 8'hFF);
      if (e == 9)  check("first_tick_pre", count_val, 16'h0000);
      if (e == 10) check("first_tick",     count_val, 16'h0001);
    end

    // Vector table
    for (int v = 0; v < 11; v++) begin
      pulses = 0;
      for (int c = 0; c < vecs[v].cycles; c++) begin
        step(vecs[v].run, vecs[v].mode, vecs[v].load && (c == 0), vecs[v].lv);
        if (count_done === 1'b1) pulses++;
      end
      check($sformatf("vec%0d_count", v),  count_val, vecs[v].exp_count);
      check($sformatf("vec%0d_pulses", v), pulses,    vecs[v].exp_pulses);
    end

    // Load on a tick cycle discards the tick and restarts the prescaler
    step(1'b1, 1'b0, 1'b1, 16'h0000);
    repeat (9) step(1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 16'h00F3);
    check("load_on_tick", count_val, 16'h0093);
    repeat (9) step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("no_early_tick", count_val, 16'h0093);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("tick_after_reload", count_val, 16'h0092);

    // Pause mid-tick preserves the prescaler phase
    step(1'b1, 1'b0, 1'b1, 16'h0040);
    repeat (4)  step(1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (37) step(1'b0, 1'b0, 1'b0, 16'h0000);
    check("paused", count_val, 16'h0040);
    repeat (5) step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("resume_pre", count_val, 16'h0040);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("resume_tick", count_val, 16'h0039);

    // Blanking of 0050, then asynchronous reset mid-scan
    step(1'b0, 1'b0, 1'b1, 16'h0050);
    for (int i = 0; i < 4; i++) seen[i] = 8'h00;
    repeat (16) begin
      step(1'b0, 1'b0, 1'b0, 16'h0000);
      case (seg_sel)
        4'b1110: seen[0] = seg_led;
        4'b1101: seen[1] = seg_led;
        4'b1011: seen[2] = seg_led;
        4'b0111: seen[3] = seg_led;
        default: ;
      endcase
    end
    check("blank_dig0", seen[0], 8'hC0);
    check("blank_dig1", seen[1], 8'h92);
    check("blank_dig2", seen[2], 8'hFF);
    check("blank_dig3", seen[3], 8'hFF);
    repeat (6) step(1'b1, 1'b0, 1'b0, 16'h0000);
    #2 sys_rst_n = 1'b0;
    #1;
    check("arst_sel",   seg_sel,    4'b1110);
    check("arst_led",   seg_led,    8'hC0);
    check("arst_count", count_val,  16'h0000);
    check("arst_zero",  count_zero, 1'b1);
    check("arst_done",  count_done, 1'b0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    model_reset();

    // Randomized traffic against the model
    m = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) m = ~m;
      l = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 2))
        0:       lv = 16'($urandom);
        1:       lv = 16'($urandom_range(0, 20));
        default: lv = 16'h9990 | 16'($urandom_range(0, 15));
      endcase
      step(r, m, l, lv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
